// File: rtl/mem_stall_responder_if.sv
// Request/response bundle between an initiator (master) and the stalling
// word memory (slave).
interface mem_stall_responder_if;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] offset;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        addr_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, offset,
    input  stall, resp_valid, rdata, addr_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, offset,
    output stall, resp_valid, rdata, addr_err
  );
endinterface

// File: rtl/mem_stall_responder.sv
// Word memory behind a fixed-latency stall handshake: accepts one access,
// stalls the initiator for LATENCY cycles, then answers in a single RESP cycle.
module mem_stall_responder #(
  parameter int WORD_DEPTH = 60,
  parameter int LATENCY    = 4
) (
  input logic                  clk,
  input logic                  rst,
  mem_stall_responder_if.slave bus
);
  localparam int IW = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          enter_resp;
  logic          accept;

  logic          wen_reg, legal_reg, resp_valid_reg;
  logic [IW-1:0] idx_reg;
  logic [31:0]   wdata_reg, rd_word_reg;

  logic [29:0]   word_off;
  logic          legal_live;
  logic [IW-1:0] idx_live;

  logic          acc_wen, acc_legal;
  logic [IW-1:0] acc_idx;
  logic [31:0]   acc_wdata;

  logic [31:0]   mem [0:WORD_DEPTH-1];

  // Unsigned window check; req_addr >= offset rules out wrap-around of the subtraction.
  assign word_off   = 30'((bus.req_addr - bus.offset) >> 2);
  assign legal_live = (bus.req_addr >= bus.offset) && (bus.req_addr[1:0] == 2'b00)
                      && (word_off < 30'(WORD_DEPTH));
  assign idx_live   = word_off[IW-1:0];

  assign accept = (state_reg == IDLE) && bus.req_valid;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (LATENCY > 1) begin
            state_next = BUSY;
            cnt_next   = 4'(LATENCY - 1);
          end else begin
            state_next = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      resp_valid_reg <= 1'b0;
      wen_reg        <= 1'b0;
      legal_reg      <= 1'b0;
      idx_reg        <= '0;
      wdata_reg      <= 32'd0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      resp_valid_reg <= enter_resp;
      if (accept) begin
        wen_reg   <= bus.req_wen;
        legal_reg <= legal_live;
        idx_reg   <= idx_live;
        wdata_reg <= bus.req_wdata;
      end
    end
  end

  // With LATENCY=1 the access happens on the accept edge, before the capture registers load.
  assign acc_wen   = (state_reg == IDLE) ? bus.req_wen   : wen_reg;
  assign acc_legal = (state_reg == IDLE) ? legal_live    : legal_reg;
  assign acc_idx   = (state_reg == IDLE) ? idx_live      : idx_reg;
  assign acc_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;

  always_ff @(posedge clk) begin
    if (enter_resp && !rst) begin
      if (acc_wen && acc_legal)
        mem[acc_idx] <= acc_wdata;
      rd_word_reg <= mem[acc_idx];
    end
  end

  assign bus.stall      = !rst && (accept || (state_reg == BUSY));
  assign bus.resp_valid = resp_valid_reg;
  assign bus.rdata      = (resp_valid_reg && legal_reg) ? (wen_reg ? wdata_reg : rd_word_reg) : 32'd0;
  assign bus.addr_err   = resp_valid_reg && !legal_reg;
endmodule

// File: doc/mem_stall_responder.md
MEM_STALL_RESPONDER -- requirements
Module: mem_stall_responder

Interface
REQ-001 Parameter WORD_DEPTH, default 60: number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 4, legal range 1..15: cycles from request acceptance to response.
REQ-003 Port clk  input  1  sole clock, rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  initiator request present.
REQ-006 Port req_wen  input  1  1 = write, 0 = read.
REQ-007 Port req_addr  input  32  byte address.
REQ-008 Port req_wdata  input  32  write data.
REQ-009 Port offset  input  32  byte address of word 0; held stable during operation.
REQ-010 Port stall  output  1  initiator must hold its request and freeze.
REQ-011 Port resp_valid  output  1  response cycle; access complete.
REQ-012 Port rdata  output  32  read data, valid when resp_valid=1.
REQ-013 Port addr_err  output  1  out-of-window or misaligned access, valid when resp_valid=1.

Function
REQ-014 Storage is array mem[0:WORD_DEPTH-1] of 32 bits; index = (req_addr - offset) >> 2.
REQ-015 Access is legal iff req_addr >= offset, req_addr[1:0] = 0 and index < WORD_DEPTH; 32-bit unsigned compare, no wrap.
REQ-016 States: IDLE, BUSY, RESP; reset state IDLE.
REQ-017 IDLE with req_valid=1: accept; capture wen/addr/wdata and legality; go to BUSY if LATENCY>1, else RESP.
REQ-018 IDLE with req_valid=0: stay IDLE.
REQ-019 BUSY: down-counter loaded with LATENCY-1 on accept; go to RESP on the edge the counter reaches 1; request inputs ignored.
REQ-020 resp_valid rises exactly LATENCY cycles after the accept cycle.
REQ-021 stall = (IDLE and req_valid) or BUSY; combinational; 0 in RESP.
REQ-022 RESP lasts exactly one cycle, then IDLE unconditionally; req_valid in RESP is not accepted (it is the completing request).
REQ-023 Next request accepted earliest in the cycle after RESP; back-to-back throughput = one access per LATENCY+1 cycles.
REQ-024 Legal write: mem[index] updated on the edge entering RESP; rdata in RESP = written data.
REQ-025 Legal read: rdata in RESP = mem[index] registered on the edge entering RESP.
REQ-026 Illegal access: no write, rdata = 0, addr_err = 1 in RESP.
REQ-027 rdata, addr_err outside RESP = 0; resp_valid registered.
REQ-028 Changes on req_* after acceptance do not affect the captured access.

Reset
REQ-029 rst=1 forces IDLE asynchronously; counter = 0, resp_valid = 0, rdata = 0, addr_err = 0.
REQ-030 stall = 0 while rst=1, regardless of req_valid.
REQ-031 Reset mid-BUSY discards the pending access; a pending write is not performed.
REQ-032 mem contents are not altered by reset; initialization is by bench hierarchical load.
REQ-033 First acceptance possible in the first cycle with rst=0 at the sampling edge.

Verification (LATENCY=4, WORD_DEPTH=60, offset=0x00010000)
REQ-034 Read 0x00010008 with mem[2]=0xDEADBEEF -> stall=1 for cycles 0..3, resp_valid=1 in cycle 4, rdata=0xDEADBEEF, addr_err=0.
REQ-035 Write 0x12345678 to 0x000100EC, then read same -> mem[59]=0x12345678 at write RESP; read returns 0x12345678.
REQ-036 Read 0x000100F0 (index 60), read 0x0000FFFC, write 0x00010002 -> each: RESP with addr_err=1, rdata=0, mem unchanged.
REQ-037 Two back-to-back reads, req_valid held high -> accept cycles 0 and 5, resp_valid in cycles 4 and 9 only.
REQ-038 Write 0xA5A5A5A5 to 0x00010010, assert rst in cycle 2 -> mem[4] unchanged, state IDLE, stall=0, resp_valid never asserted.
REQ-039 LATENCY=1 read 0x00010000 -> stall=1 only in accept cycle, resp_valid in next cycle.
